// File: rtl/output_row_packer.sv
// Packs per-column convolution result bits MSB-first into one word per output
// row and writes each row, plus an optional end-of-output marker, to the output SRAM.
`timescale 1ns/1ps
module output_row_packer #(
    parameter int                 DATA_W     = 16,
    parameter int                 ADDR_W     = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = 12'h000,
    parameter logic [DATA_W-1:0]  TERM_WORD  = 16'h00FF,
    parameter bit                 WRITE_TERM = 1'b1
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              clear,
    input  logic              res_valid,
    input  logic              res_bit,
    input  logic              res_last,
    input  logic              job_done,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              busy,
    output logic [ADDR_W-1:0] rows_written,
    output logic              col_overflow
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_TERM = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [DATA_W-1:0]  word_reg;
    logic               we_reg;
    logic               we_row_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  data_reg;
    logic               busy_reg;
    logic [ADDR_W-1:0]  ptr_reg;
    logic [ADDR_W-1:0]  rows_reg;
    logic               ovf_reg;

    logic [DATA_W-1:0]  bit_mask;
    logic               room;
    logic               take_bit;
    logic [DATA_W-1:0]  word_next;
    logic [CNT_W-1:0]   count_next;
    logic               flush;
    logic [ADDR_W-1:0]  ptr_next;
    logic [ADDR_W-1:0]  rows_next;

    // One-hot select of the word bit that column count_reg lands in (MSB first).
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
            assign bit_mask[gi] = (count_reg == CNT_W'(DATA_W - 1 - gi));
        end
    endgenerate

    assign room       = (count_reg < CNT_FULL);
    assign take_bit   = res_valid && room;
    assign word_next  = (take_bit && res_bit) ? (word_reg | bit_mask) : word_reg;
    assign count_next = take_bit ? (count_reg + CNT_W'(1)) : count_reg;
    assign flush      = (res_valid && res_last) || (job_done && (count_next != '0));

    // The pointer advances at the end of every write cycle, so anything loaded
    // during a write cycle must target the already-advanced address.
    assign ptr_next  = we_reg ? (ptr_reg + ADDR_W'(1)) : ptr_reg;
    assign rows_next = (we_reg && we_row_reg) ? (rows_reg + ADDR_W'(1)) : rows_reg;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg  <= S_ACC;
            count_reg  <= '0;
            word_reg   <= '0;
            we_reg     <= 1'b0;
            we_row_reg <= 1'b0;
            addr_reg   <= BASE_ADDR;
            data_reg   <= '0;
            busy_reg   <= 1'b0;
            ptr_reg    <= BASE_ADDR;
            rows_reg   <= '0;
            ovf_reg    <= 1'b0;
        end else if (clear) begin
            state_reg  <= S_ACC;
            count_reg  <= '0;
            word_reg   <= '0;
            we_reg     <= 1'b0;
            we_row_reg <= 1'b0;
            addr_reg   <= BASE_ADDR;
            data_reg   <= '0;
            busy_reg   <= 1'b0;
            ptr_reg    <= BASE_ADDR;
            rows_reg   <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            ptr_reg    <= ptr_next;
            rows_reg   <= rows_next;
            we_reg     <= 1'b0;
            we_row_reg <= 1'b0;
            case (state_reg)
                S_ACC: begin
                    if (res_valid && !room) begin
                        ovf_reg <= 1'b1;
                    end
                    word_reg  <= word_next;
                    count_reg <= count_next;
                    if (flush) begin
                        we_reg     <= 1'b1;
                        we_row_reg <= 1'b1;
                        addr_reg   <= ptr_next;
                        data_reg   <= word_next;
                        word_reg   <= '0;
                        count_reg  <= '0;
                    end
                    if (job_done && WRITE_TERM) begin
                        busy_reg <= 1'b1;
                        if (flush) begin
                            state_reg <= S_TERM;
                        end else begin
                            // Nothing to flush: marker goes straight onto the bus.
                            state_reg <= S_WAIT;
                            we_reg    <= 1'b1;
                            addr_reg  <= ptr_next;
                            data_reg  <= TERM_WORD;
                        end
                    end
                end
                S_TERM: begin
                    we_reg    <= 1'b1;
                    addr_reg  <= ptr_next;
                    data_reg  <= TERM_WORD;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    state_reg <= S_ACC;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_ACC;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_sram_write_enable  = we_reg;
    assign dut_sram_write_address = addr_reg;
    assign dut_sram_write_data    = data_reg;
    assign busy                   = busy_reg;
    assign rows_written           = rows_reg;
    assign col_overflow           = ovf_reg;

endmodule

// File: tb/tb_output_row_packer.sv
// Bench for output_row_packer: a table of rows plus hand-written job-end,
// overflow, clear and async-reset sequences, checked through a write scoreboard.
`timescale 1ns/1ps
module tb_output_row_packer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset_b;
    logic              clear;
    logic              res_valid;
    logic              res_bit;
    logic              res_last;
    logic              job_done;
    logic              dut_sram_write_enable;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              busy;
    logic [ADDR_W-1:0] rows_written;
    logic              col_overflow;

    output_row_packer dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .clear                  (clear),
        .res_valid              (res_valid),
        .res_bit                (res_bit),
        .res_last               (res_last),
        .job_done               (job_done),
        .dut_sram_write_enable  (dut_sram_write_enable),
        .dut_sram_write_address (dut_sram_write_address),
        .dut_sram_write_data    (dut_sram_write_data),
        .busy                   (busy),
        .rows_written           (rows_written),
        .col_overflow           (col_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          nbits;
        logic [31:0] bits;      // bits[nbits-1] is column 0
        logic [15:0] exp_data;
    } row_vec_t;

    wr_t               exp_q[$];
    wr_t               mon_e;
    row_vec_t          rows_tbl[6];
    int                checks = 0;
    int                errors = 0;
    logic [ADDR_W-1:0] exp_ptr;
    int                exp_rows;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (dut_sram_write_enable === 1'b1) begin
            $display("write addr=%03h data=%04h", dut_sram_write_address, dut_sram_write_data);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %04h@%03h expected no write",
                         dut_sram_write_data, dut_sram_write_address);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(dut_sram_write_address), mon_e.addr);
                check("write_data", 32'(dut_sram_write_data), mon_e.data);
            end
        end
    end

    task automatic expect_row(input logic [15:0] data);
        exp_q.push_back('{addr: 32'(exp_ptr), data: 32'(data)});
        exp_ptr++;
        exp_rows++;
    endtask

    task automatic expect_marker();
        exp_q.push_back('{addr: 32'(exp_ptr), data: 32'h00FF});
        exp_ptr++;
    endtask

    task automatic drive(input logic v, input logic b, input logic l, input logic d, input logic c);
        res_valid = v;
        res_bit   = b;
        res_last  = l;
        job_done  = d;
        clear     = c;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        res_bit   = 1'b0;
        res_last  = 1'b0;
        job_done  = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic send_row(input int n, input logic [31:0] bits, input logic [15:0] exp_data);
        for (int k = 0; k < n; k++) begin
            if (k == n - 1) expect_row(exp_data);
            drive(1'b1, bits[n-1-k], (k == n - 1), 1'b0, 1'b0);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        check({name, "_rows"}, 32'(rows_written), 32'(exp_rows));
    endtask

    initial begin
        rows_tbl[0] = '{16, 32'h0000FFFF, 16'hFFFF};
        rows_tbl[1] = '{16, 32'h0000AAAA, 16'hAAAA};
        rows_tbl[2] = '{1,  32'h00000001, 16'h8000};
        rows_tbl[3] = '{7,  32'h00000033, 16'h6600};
        rows_tbl[4] = '{16, 32'h00000000, 16'h0000};
        rows_tbl[5] = '{5,  32'h00000013, 16'h9800};

        reset_b = 1'b0; clear = 1'b0; res_valid = 1'b0; res_bit = 1'b0;
        res_last = 1'b0; job_done = 1'b0;
        exp_ptr = '0; exp_rows = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enable", 32'(dut_sram_write_enable), 32'd0);
        check("rst_addr",   32'(dut_sram_write_address), 32'd0);
        check("rst_data",   32'(dut_sram_write_data), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_rows",   32'(rows_written), 32'd0);
        check("rst_ovf",    32'(col_overflow), 32'd0);
        reset_b = 1'b1;
        @(posedge clk);
        #1;

        // Basic row 1,0,1,1 -> B000 at 0, then enable drops and count is 1.
        send_row(4, 32'hB, 16'hB000);
        @(posedge clk);
        #1;
        check("basic_enable_off", 32'(dut_sram_write_enable), 32'd0);
        check("basic_rows", 32'(rows_written), 32'd1);

        // Back-to-back table rows, no idle cycle between them.
        for (int i = 0; i < 6; i++) begin
            send_row(rows_tbl[i].nbits, rows_tbl[i].bits, rows_tbl[i].exp_data);
        end
        drain("table_drain");
        check("table_ovf", 32'(col_overflow), 32'd0);

        // Partial row then job_done alone; bits offered while busy must vanish.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_row(16'hE000);
        expect_marker();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("partial_busy_1", 32'(busy), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("partial_busy_2", 32'(busy), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("partial_busy_off", 32'(busy), 32'd0);
        drain("partial_drain");

        // Last bit and job_done in the same cycle.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_row(16'h4000);
        expect_marker();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("simul_busy", 32'(busy), 32'd1);
        drain("simul_drain");

        // job_done with nothing pending: marker only, one busy cycle.
        expect_marker();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("marker_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("marker_busy_off", 32'(busy), 32'd0);
        drain("marker_drain");

        // 18 ones in one row: saturates at FFFF, overflow sticks.
        send_row(18, 32'h3FFFF, 16'hFFFF);
        drain("ovf_drain");
        check("ovf_set", 32'(col_overflow), 32'd1);
        send_row(1, 32'h1, 16'h8000);
        drain("ovf_next_drain");
        check("ovf_held", 32'(col_overflow), 32'd1);

        // clear beats a same-cycle row end: no write, status wiped.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_ptr = '0;
        exp_rows = 0;
        check("clear_enable", 32'(dut_sram_write_enable), 32'd0);
        check("clear_rows", 32'(rows_written), 32'd0);
        check("clear_ovf", 32'(col_overflow), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);
        send_row(2, 32'h2, 16'h8000);
        send_row(3, 32'h7, 16'hE000);
        drain("clear_drain");

        // Async reset in the middle of a row, away from any clock edge.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset_b = 1'b0;
        #1;
        exp_ptr = '0;
        exp_rows = 0;
        check("areset_enable", 32'(dut_sram_write_enable), 32'd0);
        check("areset_addr", 32'(dut_sram_write_address), 32'd0);
        check("areset_data", 32'(dut_sram_write_data), 32'd0);
        check("areset_rows", 32'(rows_written), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        send_row(2, 32'h3, 16'hC000);
        drain("areset_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
